csr_hpm: RTL and testbench
==========================

# csr_hpm

Parametrised machine-mode counter/performance-monitor CSR bank, the next generation of the core's fixed cycle/instret counters. It holds mcycle, minstret, NUM_CTR programmable mhpmcounters with event selectors, mcountinhibit, and sticky per-counter overflow flags that raise an interrupt request. It attaches to the memory1 CSR access port beside the main CSR file, which ORs in `hpm_hit` and `hpm_dout`.

## Interface
- NUM_CTR, 4, number of mhpmcounters implemented (1..29), mapped to indices 3..3+NUM_CTR-1
- CTR_WIDTH, 48, implemented width of each mhpmcounter (32..64); mcycle/minstret always 64
- NUM_EVT, 8, number of event inputs (1..255); EVT_W = $clog2(NUM_EVT+1)

- clk_core  in  1  core clock
- reset  in  1  synchronous, active-high reset
- csr_addr  in  12  CSR address from memory1
- csr_write  in  2  00 none, 01 write, 10 set, 11 clear
- csr_din  in  32  write/set/clear operand
- hpm_hit  out  1  csr_addr decodes to an implemented register of this block
- hpm_error  out  1  write op (csr_write!=00) to a read-only address (0xC00-0xC9F) that hits
- hpm_dout  out  32  read data (0 when hpm_hit=0)
- retire  in  1  one instruction retired this cycle
- evt  in  NUM_EVT  per-cycle event pulses
- hpm_irq  out  1  OR of all overflow flags

## Operation
- Address map: mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhpmcounterN 0xB00+N / 0xB80+N, user shadows 0xC00+N / 0xC80+N (read-only, same data), mhpmeventN 0x320+N, mcountinhibit 0x320. Index 1 and unimplemented N: no hit.
- Write data: 01 -> din; 10 -> dout|din; 11 -> dout&~din, dout being the current read value of the same address.
- mcountinhibit: bit0 CY, bit2 IR, bit N for each implemented N writable; all other bits read 0. Inhibited counter holds value.
- mcycle increments each cycle unless inhibited; minstret increments when retire=1 unless inhibited.
- mhpmeventN: bits[EVT_W-1:0] SEL, bit31 OF; other bits read 0. SEL=0 or SEL>NUM_EVT: never counts. Otherwise counter increments by 1 in cycles where evt[SEL-1]=1 and not inhibited.
- CTR_WIDTH<64: bits above CTR_WIDTH read 0, writes to them discarded; high half fully reads 0 when CTR_WIDTH=32 (still hits).
- Overflow: increment from all-ones (CTR_WIDTH bits) wraps to 0 and sets OF in the same edge. OF is sticky; cleared only by a write/clear to mhpmeventN. mcycle/minstret have no OF.
- hpm_irq = |OF[N], registered state, no combinational path from inputs.
- Collisions: CSR write to a counter half wins over increment that cycle (no increment, other half unchanged, no OF). Overflow and mhpmevent write in same cycle: SEL takes written value, OF forced to 1. Low-half write does not carry into high half.

## Timing
- Reads combinational: hpm_hit, hpm_error, hpm_dout valid same cycle as csr_addr.
- Writes and increments take effect on the next clk_core rising edge; read the cycle after shows the new value.
- Event/retire pulse in cycle t visible in counter read at t+1; hpm_irq rises at t+1 for overflow at t.
- Reset (any cycle, including mid-write): all counters, mcountinhibit, SEL and OF to 0; hpm_irq 0 the cycle after reset asserted; reset dominates writes.

## Test plan
- Reset then idle 10 cycles, read 0xB00 -> 10 (±read offset fixed by bench), 0xB02 -> 0, 0xC00 equals 0xB00, hpm_irq=0.
- Write 0x323=2, pulse evt[1] 5 times, evt[0] 3 times -> 0xB03 reads 5; set mcountinhibit bit3, pulse evt[1] 4 times -> still 5.
- CTR_WIDTH=48: write 0xB83=0xFFFF, 0xB03=0xFFFFFFFE, two evt pulses -> counter 0, 0x323 bit31=1, hpm_irq=1 next cycle; clear bit31 via op 11 -> hpm_irq=0.
- Write 0xB03=0x100 in same cycle as selected event pulse -> reads 0x100; write 0xC03 -> hpm_error=1, value unchanged.
- Write 0xB00=0xFFFFFFFF -> low wraps, 0xB80 unchanged (no carry from write); subsequent free-run increment carries into 0xB80.
- Assert reset during a write to 0x320 -> mcountinhibit 0, all counters 0 after release; address 0xB01 -> hpm_hit=0, hpm_dout=0.

Source files
------------

// File: rtl/csr_hpm_if.sv
// CSR access port between the memory1 stage and the counter/performance-monitor bank.
interface csr_hpm_if;
  logic [11:0] csr_addr;
  logic [1:0]  csr_write;
  logic [31:0] csr_din;
  logic        hpm_hit;
  logic        hpm_error;
  logic [31:0] hpm_dout;

  modport master (
    output csr_addr, csr_write, csr_din,
    input  hpm_hit, hpm_error, hpm_dout
  );

  modport slave (
    input  csr_addr, csr_write, csr_din,
    output hpm_hit, hpm_error, hpm_dout
  );
endinterface

// File: rtl/csr_hpm.sv
// Machine-mode counter CSR bank: mcycle, minstret, programmable mhpmcounters with
// event selectors, mcountinhibit and sticky overflow flags driving hpm_irq.
module csr_hpm #(
  parameter int unsigned NUM_CTR   = 4,
  parameter int unsigned CTR_WIDTH = 48,
  parameter int unsigned NUM_EVT   = 8
) (
  input  logic               clk_core,
  input  logic               reset,
  csr_hpm_if.slave           csr,
  input  logic               retire,
  input  logic [NUM_EVT-1:0] evt,
  output logic               hpm_irq
);
  localparam int unsigned EVT_W    = $clog2(NUM_EVT + 1);
  localparam int unsigned EVT_EXT  = 1 << EVT_W;
  localparam int unsigned IDX_W    = 5;
  localparam logic [31:0] INH_MASK = 32'h5 | 32'(((64'd1 << NUM_CTR) - 64'd1) << 3);
  localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

  typedef enum logic [2:0] {K_NONE, K_CYCLE, K_INSTRET, K_HPM, K_EVENT, K_INHIBIT} kind_e;

  logic [63:0]          mcycle, mcycle_n, minstret, minstret_n;
  logic [31:0]          inhibit, inhibit_n;
  logic [CTR_WIDTH-1:0] ctr   [NUM_CTR];
  logic [CTR_WIDTH-1:0] ctr_n [NUM_CTR];
  logic [EVT_W-1:0]     sel   [NUM_CTR];
  logic [EVT_W-1:0]     sel_n [NUM_CTR];
  logic [NUM_CTR-1:0]   ovf, ovf_n;

  kind_e            kind;
  logic             hi, ro, idx_ok, wr_en;
  logic [IDX_W-1:0] idx, ci;
  logic [31:0]      rdata, wdata;
  logic [63:0]      rd_hpm, wr_tmp;
  logic [EVT_W-1:0] rd_sel;
  logic             rd_ovf, inc, wrap;
  logic [EVT_EXT-1:0] evt_ext;

  // Address decode: counter halves, read-only user shadows, event selectors, inhibit
  always_comb begin
    kind   = K_NONE;
    hi     = 1'b0;
    ro     = 1'b0;
    idx    = csr.csr_addr[4:0];
    ci     = idx - IDX_W'(3);
    idx_ok = (idx >= IDX_W'(3)) && (32'(idx) < NUM_CTR + 32'd3);
    unique case (csr.csr_addr[11:5])
      7'h58, 7'h5C, 7'h60, 7'h64: begin
        hi = csr.csr_addr[7];
        ro = csr.csr_addr[10];
        if (idx == IDX_W'(0))      kind = K_CYCLE;
        else if (idx == IDX_W'(2)) kind = K_INSTRET;
        else if (idx_ok)           kind = K_HPM;
      end
      7'h19: begin
        if (idx == IDX_W'(0)) kind = K_INHIBIT;
        else if (idx_ok)      kind = K_EVENT;
      end
      default: ;
    endcase
  end

  // Combinational read mux
  always_comb begin
    rd_hpm = '0;
    rd_sel = '0;
    rd_ovf = 1'b0;
    rdata  = '0;
    for (int unsigned i = 0; i < NUM_CTR; i++) begin
      if (ci == IDX_W'(i)) begin
        rd_hpm = 64'(ctr[i]);
        rd_sel = sel[i];
        rd_ovf = ovf[i];
      end
    end
    unique case (kind)
      K_CYCLE:   rdata = hi ? mcycle[63:32]   : mcycle[31:0];
      K_INSTRET: rdata = hi ? minstret[63:32] : minstret[31:0];
      K_HPM:     rdata = hi ? rd_hpm[63:32]   : rd_hpm[31:0];
      K_EVENT:   rdata = {rd_ovf, 31'(rd_sel)};
      K_INHIBIT: rdata = inhibit;
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    unique case (csr.csr_write)
      2'b10:   wdata = rdata | csr.csr_din;
      2'b11:   wdata = rdata & ~csr.csr_din;
      default: wdata = csr.csr_din;
    endcase
  end

  assign csr.hpm_hit   = (kind != K_NONE);
  assign csr.hpm_dout  = rdata;
  assign csr.hpm_error = csr.hpm_hit && ro && (csr.csr_write != 2'b00);
  assign wr_en         = csr.hpm_hit && !ro && (csr.csr_write != 2'b00);

  // Next state: increments first, then a CSR write to the same register overrides them
  always_comb begin
    mcycle_n   = mcycle;
    minstret_n = minstret;
    inhibit_n  = inhibit;
    ctr_n      = ctr;
    sel_n      = sel;
    ovf_n      = ovf;
    inc        = 1'b0;
    wrap       = 1'b0;
    wr_tmp     = '0;
    evt_ext    = EVT_EXT'({evt, 1'b0});

    if (!inhibit[0])           mcycle_n   = mcycle + 64'd1;
    if (retire && !inhibit[2]) minstret_n = minstret + 64'd1;

    if (wr_en) begin
      unique case (kind)
        K_CYCLE:   mcycle_n   = hi ? {wdata, mcycle[31:0]}   : {mcycle[63:32], wdata};
        K_INSTRET: minstret_n = hi ? {wdata, minstret[31:0]} : {minstret[63:32], wdata};
        K_INHIBIT: inhibit_n  = wdata & INH_MASK;
        default: ;
      endcase
    end

    for (int unsigned i = 0; i < NUM_CTR; i++) begin
      inc  = evt_ext[sel[i]] && !inhibit[3 + i];
      wrap = inc && (&ctr[i]);
      if (inc) begin
        ctr_n[i] = ctr[i] + CTR_ONE;
        if (wrap) ovf_n[i] = 1'b1;
      end
      if (wr_en && (ci == IDX_W'(i))) begin
        if (kind == K_HPM) begin
          wr_tmp = 64'(ctr[i]);
          if (hi) wr_tmp[63:32] = wdata;
          else    wr_tmp[31:0]  = wdata;
          ctr_n[i] = CTR_WIDTH'(wr_tmp);
          ovf_n[i] = ovf[i];
        end else if (kind == K_EVENT) begin
          sel_n[i] = wdata[EVT_W-1:0];
          ovf_n[i] = wdata[31] | wrap;
        end
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
      inhibit  <= '0;
      ctr      <= '{default: '0};
      sel      <= '{default: '0};
      ovf      <= '0;
      hpm_irq  <= 1'b0;
    end else begin
      mcycle   <= mcycle_n;
      minstret <= minstret_n;
      inhibit  <= inhibit_n;
      ctr      <= ctr_n;
      sel      <= sel_n;
      ovf      <= ovf_n;
      hpm_irq  <= |ovf_n;
    end
  end
endmodule

// File: tb/tb_csr_hpm.sv
// Scoreboard bench for csr_hpm: expected CSR reads are queued with stimulus and
// drained against the combinational read port between clock edges.
`timescale 1ns/1ps
module tb_csr_hpm;
  localparam int unsigned NUM_EVT = 8;

  logic               clk_core = 1'b0;
  logic               reset;
  logic               retire;
  logic [NUM_EVT-1:0] evt;
  logic               hpm_irq;

  csr_hpm_if bus ();

  csr_hpm #(.NUM_CTR(4), .CTR_WIDTH(48), .NUM_EVT(NUM_EVT)) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .csr      (bus),
    .retire   (retire),
    .evt      (evt),
    .hpm_irq  (hpm_irq)
  );

  always #20 clk_core = ~clk_core;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] val;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_rd(input string n, input logic [11:0] a, input logic [31:0] v, input logic h);
    exp_t e;
    e.name = n; e.addr = a; e.val = v; e.hit = h;
    sb.push_back(e);
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic h, output logic er);
    bus.csr_addr  = a;
    bus.csr_write = 2'b00;
    #1;
    d  = bus.hpm_dout;
    h  = bus.hpm_hit;
    er = bus.hpm_error;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] v);
    @(negedge clk_core);
    bus.csr_addr  = a;
    bus.csr_write = op;
    bus.csr_din   = v;
    @(negedge clk_core);
    bus.csr_write = 2'b00;
  endtask

  task automatic pulse_evt(input logic [NUM_EVT-1:0] m, input int n);
    @(negedge clk_core);
    evt = m;
    repeat (n) @(negedge clk_core);
    evt = '0;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] d; logic h, er;
    reset = 1'b1;
    repeat (3) @(negedge clk_core);
    reset = 1'b0;
    repeat (10) @(negedge clk_core);
    expect_rd("mcycle_idle",   12'hB00, 32'd10, 1'b1);
    expect_rd("mcycleh_idle",  12'hB80, 32'd0,  1'b1);
    expect_rd("minstret_idle", 12'hB02, 32'd0,  1'b1);
    expect_rd("cycle_shadow",  12'hC00, 32'd10, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    n_tests++;
    if (hpm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_after_reset: got %b required 0", hpm_irq);
    end
  endtask

  task automatic test_events();
    exp_t e; logic [31:0] d; logic h, er;
    csr_wr(12'h323, 2'b01, 32'd2);
    pulse_evt(8'h02, 5);
    pulse_evt(8'h01, 3);
    expect_rd("evt_count",  12'hB03, 32'd5, 1'b1);
    expect_rd("evt_sel_rd", 12'h323, 32'd2, 1'b1);
    csr_wr(12'h320, 2'b10, 32'h8);
    pulse_evt(8'h02, 4);
    csr_wr(12'h324, 2'b01, 32'h7FFF_FFF9);
    pulse_evt(8'hFF, 3);
    expect_rd("inhibit_rd",    12'h320, 32'h8, 1'b1);
    expect_rd("inhibit_hold",  12'hB03, 32'd5, 1'b1);
    expect_rd("sel_over_max",  12'hB04, 32'd0, 1'b1);
    expect_rd("sel_zero",      12'hB05, 32'd0, 1'b1);
    expect_rd("evt_reg_mask",  12'h324, 32'h9, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    csr_wr(12'h320, 2'b01, 32'hFFFF_FFFF);
    expect_rd("inhibit_mask", 12'h320, 32'h7D, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    csr_wr(12'h320, 2'b01, 32'h0);
  endtask

  task automatic test_retire();
    exp_t e; logic [31:0] d; logic h, er;
    @(negedge clk_core);
    retire = 1'b1;
    repeat (3) @(negedge clk_core);
    retire = 1'b0;
    expect_rd("instret_3", 12'hB02, 32'd3, 1'b1);
    csr_wr(12'h320, 2'b01, 32'h4);
    @(negedge clk_core);
    retire = 1'b1;
    repeat (2) @(negedge clk_core);
    retire = 1'b0;
    csr_wr(12'h320, 2'b01, 32'h0);
    expect_rd("instret_inhibited", 12'hB02, 32'd3, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e; logic [31:0] d; logic h, er;
    csr_wr(12'hB83, 2'b01, 32'hFFFF_FFFF);
    csr_wr(12'hB03, 2'b01, 32'hFFFF_FFFE);
    expect_rd("high_trunc", 12'hB83, 32'h0000_FFFF, 1'b1);
    expect_rd("low_loaded", 12'hB03, 32'hFFFF_FFFE, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    pulse_evt(8'h02, 2);
    expect_rd("ovf_low",  12'hB03, 32'h0,         1'b1);
    expect_rd("ovf_high", 12'hB83, 32'h0,         1'b1);
    expect_rd("ovf_flag", 12'h323, 32'h8000_0002, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    n_tests++;
    if (hpm_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_overflow: got %b required 1", hpm_irq);
    end
    @(negedge clk_core);
    #1;
    n_tests++;
    if (hpm_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_sticky: got %b required 1", hpm_irq);
    end
    csr_wr(12'h323, 2'b11, 32'h8000_0000);
    #1;
    n_tests++;
    if (hpm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_cleared: got %b required 0", hpm_irq);
    end
    expect_rd("of_clear_keeps_sel", 12'h323, 32'h2, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e; logic [31:0] d; logic h, er;
    @(negedge clk_core);
    bus.csr_addr = 12'hB03; bus.csr_write = 2'b01; bus.csr_din = 32'h100; evt = 8'h02;
    @(negedge clk_core);
    bus.csr_write = 2'b00; evt = '0;
    @(negedge clk_core);
    bus.csr_addr = 12'hC03; bus.csr_write = 2'b01; bus.csr_din = 32'h55;
    #1;
    n_tests++;
    if (bus.hpm_error !== 1'b1 || bus.hpm_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL ro_write_error: error %b hit %b required 1 1", bus.hpm_error, bus.hpm_hit);
    end
    @(negedge clk_core);
    bus.csr_write = 2'b00;
    expect_rd("write_beats_inc", 12'hB03, 32'h100, 1'b1);
    expect_rd("ro_unchanged",    12'hC03, 32'h100, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    csr_rd(12'hC03, d, h, er);
    n_tests++;
    if (er !== 1'b0) begin
      n_fail++;
      $display("FAIL ro_read_no_error: error %b required 0", er);
    end
    csr_wr(12'hB03, 2'b01, 32'hFFFF_FFFF);
    csr_wr(12'hB83, 2'b01, 32'hFFFF_FFFF);
    @(negedge clk_core);
    bus.csr_addr = 12'h323; bus.csr_write = 2'b01; bus.csr_din = 32'h3; evt = 8'h02;
    @(negedge clk_core);
    bus.csr_write = 2'b00; evt = '0;
    expect_rd("ovf_evtwr_flag", 12'h323, 32'h8000_0003, 1'b1);
    expect_rd("ovf_evtwr_low",  12'hB03, 32'h0,         1'b1);
    expect_rd("ovf_evtwr_high", 12'hB83, 32'h0,         1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    n_tests++;
    if (hpm_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_evtwr_collision: got %b required 1", hpm_irq);
    end
    csr_wr(12'h323, 2'b01, 32'h2);
    #1;
    n_tests++;
    if (hpm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_evtwr_clear: got %b required 0", hpm_irq);
    end
  endtask

  task automatic test_carry();
    exp_t e; logic [31:0] d; logic h, er;
    csr_wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    expect_rd("mcycle_wr_low",   12'hB00, 32'hFFFF_FFFF, 1'b1);
    expect_rd("mcycle_no_carry", 12'hB80, 32'h0,         1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    @(negedge clk_core);
    expect_rd("mcycle_wrap_low",  12'hB00, 32'h0, 1'b1);
    expect_rd("mcycle_carry_hi",  12'hB80, 32'h1, 1'b1);
    expect_rd("cycleh_shadow",    12'hC80, 32'h1, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    exp_t e; logic [31:0] d; logic h, er;
    csr_wr(12'hB83, 2'b01, 32'hFFFF_FFFF);
    csr_wr(12'hB03, 2'b01, 32'hFFFF_FFFF);
    pulse_evt(8'h02, 1);
    #1;
    n_tests++;
    if (hpm_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_before_reset: got %b required 1", hpm_irq);
    end
    @(negedge clk_core);
    reset = 1'b1;
    bus.csr_addr = 12'h320; bus.csr_write = 2'b01; bus.csr_din = 32'h7D;
    @(negedge clk_core);
    #1;
    n_tests++;
    if (hpm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_in_reset: got %b required 0", hpm_irq);
    end
    @(negedge clk_core);
    reset = 1'b0;
    bus.csr_write = 2'b00;
    expect_rd("rst_inhibit",  12'h320, 32'h0, 1'b1);
    expect_rd("rst_mcycle",   12'hB00, 32'h0, 1'b1);
    expect_rd("rst_mcycleh",  12'hB80, 32'h0, 1'b1);
    expect_rd("rst_minstret", 12'hB02, 32'h0, 1'b1);
    expect_rd("rst_hpm_lo",   12'hB03, 32'h0, 1'b1);
    expect_rd("rst_hpm_hi",   12'hB83, 32'h0, 1'b1);
    expect_rd("rst_event",    12'h323, 32'h0, 1'b1);
    expect_rd("miss_idx1",    12'hB01, 32'h0, 1'b0);
    expect_rd("miss_evt2",    12'h322, 32'h0, 1'b0);
    expect_rd("miss_unimpl",  12'hB07, 32'h0, 1'b0);
    expect_rd("hit_last",     12'hB06, 32'h0, 1'b1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      csr_rd(e.addr, d, h, er);
      n_tests++;
      if (d !== e.val || h !== e.hit) begin
        n_fail++;
        $display("FAIL %s: addr %h dout %h hit %b, required dout %h hit %b", e.name, e.addr, d, h, e.val, e.hit);
      end
    end
    n_tests++;
    if (hpm_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_after_release: got %b required 0", hpm_irq);
    end
  endtask

  initial begin
    reset         = 1'b1;
    retire        = 1'b0;
    evt           = '0;
    bus.csr_addr  = '0;
    bus.csr_write = 2'b00;
    bus.csr_din   = '0;
    test_reset();
    test_events();
    test_retire();
    test_overflow();
    test_collision();
    test_carry();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
